// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM states, default feedback taps and clog2 helper for the LFSR search engine
package lfsr_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FOUND, EXHAUSTED} state_e;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/barrel_rotator_n.sv
// barrel_rotator_n: combinational rotate-left of a WIDTH-bit word by amt_i mod WIDTH
module barrel_rotator_n
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEL_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0] amt_i,
  output logic [WIDTH-1:0] data_o
);
  logic [SEL_W-1:0] amt;
  // right shift by WIDTH yields zero, so amt=0 passes data_i straight through
  assign amt = SEL_W'(32'(amt_i) % WIDTH);
  assign data_o = (data_i << amt) | (data_i >> (WIDTH - 32'(amt)));
endmodule

// File: rtl/lfsr_search_engine.sv
// lfsr_search_engine: steps a Fibonacci LFSR from a seed until an external match,
// step-budget exhaustion or abort; exposes the register rotated by X
module lfsr_search_engine
  import lfsr_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] MAX_STEPS = '1,
  parameter int              SEL_W     = clog2(WIDTH)
) (
  input  logic             LFSR_Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Seed,
  input  logic [SEL_W-1:0] X,
  input  logic             LFSR_Enable,
  input  logic             Compare_Found,
  input  logic             Abort,
  output logic [WIDTH-1:0] LFSR_OUT,
  output logic [WIDTH-1:0] Step_Count,
  output logic             Busy,
  output logic             Done,
  output logic             Match,
  output logic             Timeout
);
  state_e           state_q;
  logic [WIDTH-1:0] seed_q, lfsr_q, cnt_q, lfsr_d;
  logic             busy_q, done_q, match_q, timeout_q;
  assign lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  always_ff @(posedge LFSR_Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      seed_q    <= WIDTH'(1);
      lfsr_q    <= WIDTH'(1);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (Start) begin
          state_q   <= LOAD;
          busy_q    <= 1'b1;
          seed_q    <= (Seed == '0) ? WIDTH'(1) : Seed;
          cnt_q     <= '0;
          match_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
        LOAD: if (Abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
          lfsr_q  <= seed_q;
        end
        // priority: abort, then match, then budget exhaustion, then stepping
        RUN: if (Abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else if (Compare_Found) begin
          state_q <= FOUND;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          match_q <= 1'b1;
        end else if (cnt_q == MAX_STEPS) begin
          state_q   <= EXHAUSTED;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          timeout_q <= 1'b1;
        end else if (LFSR_Enable) begin
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  barrel_rotator_n #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_rot (
    .data_i(lfsr_q),
    .amt_i (X),
    .data_o(LFSR_OUT)
  );
  assign Step_Count = cnt_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Match      = match_q;
  assign Timeout    = timeout_q;
endmodule

// File: tb/tb_lfsr_search_engine.sv
// tb_lfsr_search_engine: directed and randomized checks of the LFSR search engine against a behavioural model
module tb_lfsr_search_engine;
  logic        clk = 1'b0;
  logic        rst, start, en, found, abort, start3, found3;
  logic [15:0] seed;
  logic [3:0]  x;
  logic [15:0] out, cnt, out3, cnt3;
  logic        busy, done, match, tmo, busy3, done3, match3, tmo3;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_reg;
  int          m_cnt;

  always #5 clk = ~clk;

  lfsr_search_engine dut (
    .LFSR_Clock(clk), .Reset(rst), .Start(start), .Seed(seed), .X(x),
    .LFSR_Enable(en), .Compare_Found(found), .Abort(abort),
    .LFSR_OUT(out), .Step_Count(cnt), .Busy(busy), .Done(done),
    .Match(match), .Timeout(tmo)
  );

  lfsr_search_engine #(.MAX_STEPS(16'd3)) dut3 (
    .LFSR_Clock(clk), .Reset(rst), .Start(start3), .Seed(seed), .X(x),
    .LFSR_Enable(en), .Compare_Found(found3), .Abort(1'b0),
    .LFSR_OUT(out3), .Step_Count(cnt3), .Busy(busy3), .Done(done3),
    .Match(match3), .Timeout(tmo3)
  );

  // next value: shift left by one, new low bit is odd parity of the tapped bits
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] m;
    int ones;
    m = v & 16'hB400;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(m[i]);
    return 16'((int'(v) * 2) % 65536 + ones % 2);
  endfunction

  function automatic logic [15:0] ref_rot(input logic [15:0] v, input int amt);
    int s;
    s = amt % 16;
    return 16'((int'(v) * (1 << s)) % 65536 + int'(v) / (1 << (16 - s)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mism, first_ret, n;
    rst = 1'b1; start = 1'b0; en = 1'b0; found = 1'b0; abort = 1'b0;
    start3 = 1'b0; found3 = 1'b0; seed = '0; x = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_out", out, 16'h0001);
    chk("rst3_cnt", cnt3, 0);
    x = 4'd5;
    #1;
    chk("rst_rot", out, ref_rot(16'h0001, 5));
    x = '0;
    // full period from seed 1
    seed = 16'h0001; start = 1'b1; en = 1'b1;
    tick;
    chk("load_busy", busy, 1);
    start = 1'b0;
    tick;
    chk("load_out", out, 16'h0001);
    tick;
    chk("first_step", out, 16'h0002);
    chk("first_cnt", cnt, 1);
    m_reg = 16'h0002; mism = 0; first_ret = 0;
    for (int i = 2; i <= 65535; i++) begin
      tick;
      m_reg = ref_step(m_reg);
      if (out !== m_reg) mism++;
      if (out == 16'h0001 && first_ret == 0) first_ret = i;
    end
    chk("seq_model", mism, 0);
    chk("period", first_ret, 65535);
    chk("seq_end_cnt", cnt, 65535);
    tick;
    chk("exh_timeout", tmo, 1);
    chk("exh_done", done, 1);
    chk("exh_busy", busy, 0);
    chk("exh_out", out, 16'h0001);
    chk("exh_match", match, 0);
    en = 1'b0;
    tick;
    chk("exh_done_pulse", done, 0);
    chk("exh_timeout_hold", tmo, 1);
    // zero seed, ignored restart, hold, mid-search reset
    seed = 16'h0000; start = 1'b1;
    tick;
    chk("start_clr_timeout", tmo, 0);
    start = 1'b0;
    tick;
    chk("zero_seed", out, 16'h0001);
    m_reg = 16'h0001; m_cnt = 0; en = 1'b1;
    repeat (9) begin
      tick;
      m_reg = ref_step(m_reg);
      m_cnt++;
    end
    start = 1'b1; seed = 16'hABCD;
    tick;
    m_reg = ref_step(m_reg);
    m_cnt++;
    start = 1'b0;
    chk("ign_start_cnt", cnt, m_cnt);
    chk("ign_start_out", out, m_reg);
    chk("ign_start_busy", busy, 1);
    en = 1'b0;
    repeat (3) tick;
    chk("hold_cnt", cnt, 10);
    chk("hold_out", out, m_reg);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_out", out, 16'h0001);
    // match with rotation
    seed = 16'h0001; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    en = 1'b1;
    tick;
    en = 1'b0; x = 4'd4;
    #1;
    chk("rot4", out, 16'h0020);
    found = 1'b1; en = 1'b1;
    tick;
    found = 1'b0; en = 1'b0;
    chk("found_match", match, 1);
    chk("found_done", done, 1);
    chk("found_busy", busy, 0);
    chk("found_out", out, 16'h0020);
    chk("found_cnt", cnt, 1);
    tick;
    chk("found_done_once", done, 0);
    chk("found_match_hold", match, 1);
    x = '0;
    // abort in LOAD leaves the register untouched
    seed = 16'h1234; start = 1'b1;
    tick;
    start = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_load_done", done, 1);
    chk("abort_load_busy", busy, 0);
    chk("abort_load_match", match, 0);
    chk("abort_load_out", out, 16'h0002);
    // abort beats a simultaneous match
    seed = 16'h00F0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    en = 1'b1;
    tick;
    m_reg = ref_step(16'h00F0);
    abort = 1'b1; found = 1'b1;
    tick;
    abort = 1'b0; found = 1'b0; en = 1'b0;
    chk("abort_run_done", done, 1);
    chk("abort_run_match", match, 0);
    chk("abort_run_timeout", tmo, 0);
    chk("abort_run_busy", busy, 0);
    chk("abort_run_out", out, m_reg);
    // randomized searches
    repeat (6) begin
      seed = 16'($urandom); start = 1'b1; x = 4'($urandom);
      tick;
      start = 1'b0;
      m_reg = (seed == 16'h0000) ? 16'h0001 : seed;
      m_cnt = 0;
      tick;
      chk("rnd_load", out, ref_rot(m_reg, int'(x)));
      n = int'($urandom_range(5, 40));
      for (int k = 0; k < n; k++) begin
        en = 1'($urandom); x = 4'($urandom);
        tick;
        if (en) begin
          m_reg = ref_step(m_reg);
          m_cnt++;
        end
        chk("rnd_out", out, ref_rot(m_reg, int'(x)));
        chk("rnd_cnt", cnt, m_cnt);
      end
      found = 1'b1; en = 1'b1;
      tick;
      found = 1'b0; en = 1'b0;
      chk("rnd_match", match, 1);
      chk("rnd_hold", out, ref_rot(m_reg, int'(x)));
      chk("rnd_hold_cnt", cnt, m_cnt);
      tick;
    end
    x = '0;
    // small step budget
    seed = 16'h0001; start3 = 1'b1; en = 1'b1;
    tick;
    start3 = 1'b0;
    repeat (4) tick;
    chk("t3_cnt", cnt3, 3);
    chk("t3_busy", busy3, 1);
    tick;
    chk("t3_timeout", tmo3, 1);
    chk("t3_done", done3, 1);
    chk("t3_cnt_end", cnt3, 3);
    chk("t3_match", match3, 0);
    tick;
    chk("t3_done_pulse", done3, 0);
    seed = 16'h0005; start3 = 1'b1;
    tick;
    chk("t3_clr_timeout", tmo3, 0);
    start3 = 1'b0;
    repeat (4) tick;
    chk("t3_out", out3, ref_step(ref_step(ref_step(16'h0005))));
    found3 = 1'b1;
    tick;
    found3 = 1'b0; en = 1'b0;
    chk("both_match", match3, 1);
    chk("both_timeout", tmo3, 0);
    chk("both_done", done3, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
